rvvi_trace_emitter: RTL and testbench



---
 rtl/rvvi_trace_pkg.sv | 31 +++
 rtl/rvvi_trace_fifo.sv | 52 +++++
 rtl/rvvi_trace_emitter.sv | 128 ++++++++++++
 tb/tb_rvvi_trace_emitter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvvi_trace_pkg.sv
// Shared types for the RVVI retirement trace emitter: the buffered record layout,
// the intake FSM states and the loss-counter width.
package rvvi_trace_pkg;

  // Records are stored at the widest supported width; the top truncates on output.
  localparam int unsigned XLEN_MAX   = 64;
  localparam int unsigned ILEN_MAX   = 64;
  localparam int unsigned ORDER_W    = 64;
  localparam int unsigned DROP_CNT_W = 16;

  typedef struct packed {
    logic [ORDER_W-1:0]  order;
    logic [ILEN_MAX-1:0] insn;
    logic [XLEN_MAX-1:0] pc;
    logic                trap;
    logic [31:0]         x_wb;
    logic [XLEN_MAX-1:0] x_wdata;
  } trace_rec_t;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } trace_state_e;

  // x0 writes are architecturally invisible, so they never appear in the mask.
  function automatic logic [31:0] wb_mask(input logic [4:0] rd, input logic we);
    return (we && (rd != 5'd0)) ? (32'd1 << rd) : 32'd0;
  endfunction

endpackage

// File: rtl/rvvi_trace_fifo.sv
// Synchronous FIFO of trace records. Pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter.
module rvvi_trace_fifo
  import rvvi_trace_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  trace_rec_t               data_i,
  input  logic                     pop_i,
  output trace_rec_t               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0] wptr_q, wptr_d;
  logic [Aw:0] rptr_q, rptr_d;
  trace_rec_t  mem_q [Depth];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q[Aw-1:0]] <= data_i;
  end

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign count_o = wptr_q - rptr_q;
  // Head reads as zero when empty so stale storage never leaks onto the trace bus.
  assign data_o  = empty_o ? '0 : mem_q[rptr_q[Aw-1:0]];

endmodule

// File: rtl/rvvi_trace_emitter.sv
// Captures one retirement per cycle, tags it with a program order number, buffers it and
// presents it to the coverage consumer; also handles back-pressure, loss counting and drain.
module rvvi_trace_emitter
  import rvvi_trace_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ret_valid,
  input  logic [ILEN-1:0]       ret_insn,
  input  logic [XLEN-1:0]       ret_pc,
  input  logic                  ret_trap,
  input  logic [4:0]            ret_rd,
  input  logic                  ret_rd_we,
  input  logic [XLEN-1:0]       ret_rd_wdata,
  output logic                  ret_stall,
  output logic                  trc_valid,
  input  logic                  trc_ready,
  output logic [63:0]           trc_order,
  output logic [ILEN-1:0]       trc_insn,
  output logic [XLEN-1:0]       trc_pc_rdata,
  output logic                  trc_trap,
  output logic [31:0]           trc_x_wb,
  output logic [XLEN-1:0]       trc_x_wdata,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  // Stall one entry early so an event already in flight from the core still fits.
  localparam logic [CntW-1:0] StallLevel = CntW'(DEPTH - 1);

  trace_state_e            state_q, state_d;
  logic [ORDER_W-1:0]      order_q, order_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  trace_rec_t              rec_in, rec_out;
  logic                    fifo_full, fifo_empty;
  logic [CntW-1:0]         fifo_count;
  logic                    in_run, accept, push, pop, drop;

  assign in_run = (state_q == StRun);
  assign accept = in_run && ret_valid;
  assign pop    = !fifo_empty && trc_ready;
  assign push   = accept && (!fifo_full || pop);
  assign drop   = accept && fifo_full && !pop;

  always_comb begin
    rec_in         = '0;
    rec_in.order   = order_q;
    rec_in.insn    = ILEN_MAX'(ret_insn);
    rec_in.pc      = XLEN_MAX'(ret_pc);
    rec_in.trap    = ret_trap;
    rec_in.x_wb    = wb_mask(ret_rd, ret_rd_we);
    rec_in.x_wdata = (rec_in.x_wb != 32'd0) ? XLEN_MAX'(ret_rd_wdata) : '0;
  end

  rvvi_trace_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (pop),
    .data_o  (rec_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (drain_req)  state_d = StDrain;
      // Drain ignores drain_req falling; only an empty FIFO ends it.
      StDrain: if (fifo_empty) state_d = StDone;
      StDone:  if (!drain_req) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Dropped events still consume an order number so the consumer sees the gap.
  always_comb begin
    order_d    = order_q + {{(ORDER_W-1){1'b0}}, accept};
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      order_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      order_q    <= order_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ret_stall    = (fifo_count >= StallLevel) || !in_run;
  assign drain_done   = (state_q == StDone);
  assign overflow     = overflow_q;
  assign drop_count   = drop_cnt_q;

  assign trc_valid    = !fifo_empty;
  assign trc_order    = rec_out.order;
  assign trc_insn     = rec_out.insn[ILEN-1:0];
  assign trc_pc_rdata = rec_out.pc[XLEN-1:0];
  assign trc_trap     = rec_out.trap;
  assign trc_x_wb     = rec_out.x_wb;
  assign trc_x_wdata  = rec_out.x_wdata[XLEN-1:0];

  // Upper record bits are unused for narrower XLEN/ILEN configurations.
  logic unused_rec;
  assign unused_rec = ^rec_out;

endmodule

// File: tb/tb_rvvi_trace_emitter.sv
// Directed scoreboard bench for rvvi_trace_emitter: expected records are queued as events
// are driven and compared field by field whenever the consumer handshake completes.
module tb_rvvi_trace_emitter;

  localparam int KPush   = 0;
  localparam int KDrop   = 1;
  localparam int KIgnore = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ret_valid;
  logic [31:0] ret_insn;
  logic [31:0] ret_pc;
  logic        ret_trap;
  logic [4:0]  ret_rd;
  logic        ret_rd_we;
  logic [31:0] ret_rd_wdata;
  logic        ret_stall;
  logic        trc_valid;
  logic        trc_ready;
  logic [63:0] trc_order;
  logic [31:0] trc_insn;
  logic [31:0] trc_pc_rdata;
  logic        trc_trap;
  logic [31:0] trc_x_wb;
  logic [31:0] trc_x_wdata;
  logic        drain_req;
  logic        drain_done;
  logic        overflow;
  logic [15:0] drop_count;

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        trap;
    logic [31:0] x_wb;
    logic [31:0] x_wdata;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ev_id = 0;
  logic [63:0] order_exp = '0;

  rvvi_trace_emitter #(
    .XLEN  (32),
    .ILEN  (32),
    .DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ret_valid    (ret_valid),
    .ret_insn     (ret_insn),
    .ret_pc       (ret_pc),
    .ret_trap     (ret_trap),
    .ret_rd       (ret_rd),
    .ret_rd_we    (ret_rd_we),
    .ret_rd_wdata (ret_rd_wdata),
    .ret_stall    (ret_stall),
    .trc_valid    (trc_valid),
    .trc_ready    (trc_ready),
    .trc_order    (trc_order),
    .trc_insn     (trc_insn),
    .trc_pc_rdata (trc_pc_rdata),
    .trc_trap     (trc_trap),
    .trc_x_wb     (trc_x_wb),
    .trc_x_wdata  (trc_x_wdata),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Samples the consumer side on the falling edge, then advances past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (trc_valid && trc_ready) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_record: observed order %0d expected no record", trc_order);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rec_order", trc_order, e.order);
        chk("rec_insn", 64'(trc_insn), 64'(e.insn));
        chk("rec_pc", 64'(trc_pc_rdata), 64'(e.pc));
        chk("rec_trap", 64'(trc_trap), 64'(e.trap));
        chk("rec_x_wb", 64'(trc_x_wb), 64'(e.x_wb));
        chk("rec_x_wdata", 64'(trc_x_wdata), 64'(e.x_wdata));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ev(input logic [4:0] rd, input logic we, input logic [31:0] wd,
                          input logic trap, input int kind);
    exp_t e;
    ret_valid    = 1'b1;
    ret_rd       = rd;
    ret_rd_we    = we;
    ret_rd_wdata = wd;
    ret_trap     = trap;
    ret_insn     = 32'h0000_0013 + 32'(ev_id) * 32'h100;
    ret_pc       = 32'h8000_0000 + 32'(ev_id) * 32'd4;
    ev_id++;
    if (kind == KPush) begin
      e.order   = order_exp;
      e.insn    = ret_insn;
      e.pc      = ret_pc;
      e.trap    = trap;
      e.x_wb    = (we && rd != 5'd0) ? (32'd1 << rd) : 32'd0;
      e.x_wdata = (e.x_wb != 32'd0) ? wd : 32'd0;
      sb.push_back(e);
    end
    if (kind != KIgnore) order_exp++;
  endtask

  task automatic drain_sb(input string tag);
    ret_valid = 1'b0;
    trc_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; ret_valid = 1'b0; ret_insn = '0; ret_pc = '0; ret_trap = 1'b0;
    ret_rd = '0; ret_rd_we = 1'b0; ret_rd_wdata = '0; trc_ready = 1'b0; drain_req = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trc_valid", 64'(trc_valid), 64'd0);
    chk("rst_trc_order", trc_order, 64'd0);
    chk("rst_trc_insn", 64'(trc_insn), 64'd0);
    chk("rst_trc_pc", 64'(trc_pc_rdata), 64'd0);
    chk("rst_trc_x_wb", 64'(trc_x_wb), 64'd0);
    chk("rst_trc_x_wdata", 64'(trc_x_wdata), 64'd0);
    chk("rst_ret_stall", 64'(ret_stall), 64'd0);
    chk("rst_drain_done", 64'(drain_done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back events, orders 0..4, one-cycle latency
    trc_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("b2b_latency_valid", 64'(trc_valid), (k > 0) ? 64'd1 : 64'd0);
      chk("b2b_no_stall", 64'(ret_stall), 64'd0);
      drive_ev(5'(k + 1), 1'b1, 32'hA000_0000 + 32'(k), 1'b0, KPush);
      tick();
    end
    drain_sb("b2b_drained");

    // Writeback masking: x0 write suppressed, rd=5 visible; trap flag carried
    drive_ev(5'd0, 1'b1, 32'h0000_DEAD, 1'b1, KPush);
    tick();
    drive_ev(5'd5, 1'b1, 32'h1234_5678, 1'b0, KPush);
    tick();
    drive_ev(5'd9, 1'b0, 32'h5555_AAAA, 1'b0, KPush);
    tick();
    drain_sb("mask_drained");

    // Overflow: ten events into a stalled consumer
    trc_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("ovf_stall_level", 64'(ret_stall), (k >= 7) ? 64'd1 : 64'd0);
      drive_ev(5'd3, 1'b1, 32'(k), 1'b0, (k < 8) ? KPush : KDrop);
      tick();
    end
    ret_valid = 1'b0;
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop_count", 64'(drop_count), 64'd2);
    chk("ovf_head_valid", 64'(trc_valid), 64'd1);
    chk("ovf_head_order", trc_order, sb[0].order);
    tick();
    tick();
    chk("ovf_hold_order", trc_order, sb[0].order);
    chk("ovf_hold_insn", 64'(trc_insn), 64'(sb[0].insn));
    drain_sb("ovf_drained");
    drive_ev(5'd4, 1'b1, 32'hCAFE_0001, 1'b0, KPush);
    tick();
    drain_sb("ovf_gap_drained");

    // Full FIFO with simultaneous push and pop
    trc_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive_ev(5'd7, 1'b1, 32'hB000_0000 + 32'(k), 1'b0, KPush);
      tick();
    end
    chk("full_stall", 64'(ret_stall), 64'd1);
    trc_ready = 1'b1;
    drive_ev(5'd8, 1'b1, 32'hB000_00FF, 1'b0, KPush);
    tick();
    ret_valid = 1'b0;
    trc_ready = 1'b0;
    chk("full_pushpop_no_drop", 64'(drop_count), 64'd2);
    chk("full_pushpop_stall", 64'(ret_stall), 64'd1);
    tick();
    drain_sb("full_drained");

    // Drain: drain_req arrives with the third event, later events are ignored
    trc_ready = 1'b0;
    drive_ev(5'd1, 1'b1, 32'hD000_0000, 1'b0, KPush);
    tick();
    drive_ev(5'd2, 1'b1, 32'hD000_0001, 1'b0, KPush);
    tick();
    drive_ev(5'd3, 1'b1, 32'hD000_0002, 1'b0, KPush);
    drain_req = 1'b1;
    tick();
    chk("drain_stall", 64'(ret_stall), 64'd1);
    chk("drain_not_done", 64'(drain_done), 64'd0);
    drive_ev(5'd4, 1'b1, 32'hD000_0003, 1'b0, KIgnore);
    tick();
    drive_ev(5'd5, 1'b1, 32'hD000_0004, 1'b0, KIgnore);
    tick();
    ret_valid = 1'b0;
    trc_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_fifo_empty", 64'(trc_valid), 64'd0);
    chk("drain_done_late", 64'(drain_done), 64'd0);
    tick();
    chk("drain_done_rise", 64'(drain_done), 64'd1);
    chk("done_stall", 64'(ret_stall), 64'd1);
    drain_req = 1'b0;
    tick();
    chk("back_to_run", 64'(drain_done), 64'd0);
    chk("run_no_stall", 64'(ret_stall), 64'd0);
    drive_ev(5'd6, 1'b1, 32'hD000_0005, 1'b0, KPush);
    tick();
    drain_sb("post_drain_drained");

    // Reset mid-stream with four records buffered
    trc_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_ev(5'd10, 1'b1, 32'hE000_0000 + 32'(k), 1'b0, KPush);
      tick();
    end
    ret_valid = 1'b0;
    chk("prerst_valid", 64'(trc_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(trc_valid), 64'd0);
    chk("midrst_order", trc_order, 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    chk("midrst_drop_count", 64'(drop_count), 64'd0);
    sb.delete();
    order_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    trc_ready = 1'b1;
    drive_ev(5'd11, 1'b1, 32'hF000_0000, 1'b0, KPush);
    tick();
    drain_sb("postrst_drained");
    chk("postrst_overflow", 64'(overflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
